// File: rtl/alu_pkg.sv
// Shared definitions for the combinational ALU and the blocks that drive it.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam int unsigned MULDIV_ITERS = 32;

endpackage

// File: rtl/alu_carry_recover.sv
// Rebuilds the carry-out of a 32-bit ALU add/sub from operand and result MSBs.
module alu_carry_recover (
  input  logic a31_i,
  input  logic b31_i,
  input  logic r31_i,
  input  logic op2_i,
  output logic carry_o
);

  logic b_eff;

  // op[2] selects subtract, where the ALU inverts B internally; carry=1 means no borrow.
  assign b_eff   = b31_i ^ op2_i;
  assign carry_o = (a31_i & b_eff) | ((a31_i | b_eff) & ~r31_i);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned 32x32 multiply and 32/32 divide built on the shared combinational ALU.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_div,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_dbz,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  localparam logic [1:0] StIdle = IDLE;
  localparam logic [1:0] StRun  = RUN;
  localparam logic [1:0] StDone = DONE;

  localparam int unsigned      CntW    = $clog2(MULDIV_ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(MULDIV_ITERS - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             div_q, div_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] rem_shift;
  logic             rem_msb;
  logic             carry;
  logic             unused_ok;

  // Operation is unsigned, so the ALU's signed overflow flag carries no information.
  assign unused_ok = alu_overflow;

  assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign rem_msb   = hi_q[WIDTH-1];

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_dbz   = dbz_q;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_AND;
    if (state_q == StRun) begin
      alu_b = opb_q;
      if (div_q) begin
        alu_op = OP_SUB;
        alu_a  = rem_shift;
      end else begin
        alu_op = OP_ADD;
        alu_a  = hi_q;
      end
    end
  end

  alu_carry_recover u_carry (
    .a31_i   (alu_a[WIDTH-1]),
    .b31_i   (alu_b[WIDTH-1]),
    .r31_i   (alu_result[WIDTH-1]),
    .op2_i   (alu_op[2]),
    .carry_o (carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          div_d = req_div;
          opb_d = req_b;
          cnt_d = '0;
          if (req_div && (req_b == '0)) begin
            hi_d    = req_a;
            lo_d    = DBZ_QUOTIENT;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            hi_d    = '0;
            lo_d    = req_a;
            dbz_d   = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (div_q) begin
          // Restoring step: keep the difference when the 33-bit remainder covers the divisor.
          if (rem_msb || carry) begin
            hi_d = alu_result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_shift;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else if (lo_q[0]) begin
          hi_d = {carry, alu_result[WIDTH-1:1]};
          lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
    end
  end

  a_alu_zero_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StRun) |-> (alu_zero == (alu_result == '0)));

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed checks of alu_muldiv_seq against a plain-arithmetic reference.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_div;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_dbz;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;

  int vectors;
  int miscompares;

  alu_muldiv_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_div      (req_div),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hi       (rsp_hi),
    .rsp_lo       (rsp_lo),
    .rsp_dbz      (rsp_dbz),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the existing combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a + alu_b;
      3'b110: alu_result = alu_a - alu_b;
      3'b111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
    alu_zero     = (alu_result == '0);
    alu_overflow = 1'b0;
  end

  function automatic void ref_model(input logic div, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic dbz, output int lat);
    logic [63:0] p;
    if (div) begin
      if (b == 0) begin
        hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 1;
      end else begin
        hi = a % b; lo = a / b; dbz = 1'b0; lat = 33;
      end
    end else begin
      p  = 64'(a) * 64'(b);
      hi = p[63:32]; lo = p[31:0]; dbz = 1'b0; lat = 33;
    end
  endfunction

  // Issues one request and waits (bounded) for rsp_valid; leaves the response pending.
  task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat, output bit alu_busy, output bit timeout);
    int guard;
    guard   = 0;
    timeout = 1'b0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) timeout = 1'b1;
    req_valid = 1'b1; req_div = div; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_div = 1'($urandom); req_a = $urandom; req_b = $urandom;
    lat      = 1;
    alu_busy = 1'b0;
    while (!rsp_valid && lat < 100) begin
      if (alu_op !== 3'b000) alu_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) timeout = 1'b1;
    hi = rsp_hi; lo = rsp_lo; dbz = rsp_dbz;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_div = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_dbz, rsp_hi, rsp_lo} !== {3'b100, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_rsp: got rdy=%b vld=%b dbz=%b hi=%h lo=%h want rdy=1 vld=0 dbz=0 hi=0 lo=0",
               req_ready, rsp_valid, rsp_dbz, rsp_hi, rsp_lo);
    end
    vectors++;
    if ({alu_op, alu_a, alu_b} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_alu: got op=%b a=%h b=%h want op=000 a=0 b=0", alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_directed();
    logic        t_div [5];
    logic [31:0] t_a   [5];
    logic [31:0] t_b   [5];
    logic [31:0] t_hi  [5];
    logic [31:0] t_lo  [5];
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
    bit          busy, tmo;
    t_div = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t_a   = '{32'd7, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 32'h8000_0001};
    t_b   = '{32'd6, 32'hFFFF_FFFF, 32'd7,   32'h8000_0000, 32'h0000_0002};
    t_hi  = '{32'd0, 32'hFFFF_FFFE, 32'd2,   32'h7FFF_FFFF, 32'h0000_0001};
    t_lo  = '{32'h2A, 32'h0000_0001, 32'd14, 32'd1,         32'h0000_0002};
    for (int i = 0; i < 5; i++) begin
      run_op(t_div[i], t_a[i], t_b[i], hi, lo, dbz, lat, busy, tmo);
      vectors++;
      if (tmo || {hi, lo, dbz} !== {t_hi[i], t_lo[i], 1'b0}) begin
        miscompares++;
        $display("FAIL directed_%0d: got hi=%h lo=%h dbz=%b tmo=%b want hi=%h lo=%h dbz=0",
                 i, hi, lo, dbz, tmo, t_hi[i], t_lo[i]);
      end
      vectors++;
      if (lat !== 33) begin
        miscompares++;
        $display("FAIL directed_lat_%0d: got %0d cycles want 33", i, lat);
      end
      finish_rsp();
    end
  endtask

  task automatic test_dbz();
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
    bit          busy, tmo;
    run_op(1'b1, 32'h1234, 32'd0, hi, lo, dbz, lat, busy, tmo);
    vectors++;
    if (tmo || {hi, lo, dbz} !== {32'h1234, 32'hFFFF_FFFF, 1'b1}) begin
      miscompares++;
      $display("FAIL dbz_value: got hi=%h lo=%h dbz=%b want hi=00001234 lo=ffffffff dbz=1",
               hi, lo, dbz);
    end
    vectors++;
    if (lat !== 1 || busy || alu_op !== 3'b000) begin
      miscompares++;
      $display("FAIL dbz_timing: got lat=%0d alu_used=%b op=%b want lat=1 alu_used=0 op=000",
               lat, busy, alu_op);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, a2, b2, hi, lo, ehi, elo;
    logic        dbz, edbz;
    int          lat, elat, held_bad;
    bit          busy, tmo;
    a = $urandom; b = $urandom;
    ref_model(1'b0, a, b, ehi, elo, edbz, elat);
    run_op(1'b0, a, b, hi, lo, dbz, lat, busy, tmo);
    vectors++;
    if (tmo || {hi, lo, dbz} !== {ehi, elo, edbz}) begin
      miscompares++;
      $display("FAIL bp_first: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
               hi, lo, dbz, ehi, elo, edbz);
    end
    a2 = $urandom; b2 = $urandom | 32'd1;
    req_valid = 1'b1; req_div = 1'b1; req_a = a2; req_b = b2;
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({rsp_valid, req_ready, rsp_hi, rsp_lo, rsp_dbz} !== {2'b10, ehi, elo, edbz}) held_bad++;
    end
    vectors++;
    if (held_bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", held_bad);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    ref_model(1'b1, a2, b2, ehi, elo, edbz, elat);
    vectors++;
    if ({rsp_hi, rsp_lo, rsp_dbz} !== {ehi, elo, edbz} || lat !== elat) begin
      miscompares++;
      $display("FAIL bp_second: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
               rsp_hi, rsp_lo, lat, ehi, elo, elat);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
    bit          busy, tmo, spurious;
    req_valid = 1'b1; req_div = 1'b0; req_a = $urandom; req_b = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({req_ready, rsp_valid, alu_op, rsp_hi, rsp_lo} !== {2'b10, 3'b000, 64'd0}) begin
      miscompares++;
      $display("FAIL midreset_state: got rdy=%b vld=%b op=%b hi=%h lo=%h want rdy=1 vld=0 op=000 hi=0 lo=0",
               req_ready, rsp_valid, alu_op, rsp_hi, rsp_lo);
    end
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      miscompares++;
      $display("FAIL midreset_idle: got activity after reset want none");
    end
    run_op(1'b0, 32'd3, 32'd5, hi, lo, dbz, lat, busy, tmo);
    vectors++;
    if (tmo || {hi, lo, dbz} !== {32'd0, 32'd15, 1'b0} || lat !== 33) begin
      miscompares++;
      $display("FAIL midreset_next: got hi=%h lo=%h dbz=%b lat=%0d want hi=0 lo=f dbz=0 lat=33",
               hi, lo, dbz, lat);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, ehi, elo;
    logic        edbz;
    int          elat, cyc, n_hs, last_hs, bad_gap, bad_rsp;
    a = $urandom; b = $urandom;
    ref_model(1'b0, a, b, ehi, elo, edbz, elat);
    req_valid = 1'b1; req_div = 1'b0; req_a = a; req_b = b; rsp_ready = 1'b1;
    n_hs = 0; last_hs = 0; bad_gap = 0; bad_rsp = 0; cyc = 0;
    while (n_hs < 4 && cyc < 400) begin
      if (req_ready) begin
        if (n_hs > 0 && (cyc - last_hs) != 34) bad_gap++;
        last_hs = cyc;
        n_hs++;
      end
      if (rsp_valid && {rsp_hi, rsp_lo, rsp_dbz} !== {ehi, elo, edbz}) bad_rsp++;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    while (!req_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (n_hs !== 4 || bad_gap !== 0) begin
      miscompares++;
      $display("FAIL b2b_rate: got %0d handshakes, %0d bad gaps want 4 handshakes, 0 bad gaps",
               n_hs, bad_gap);
    end
    vectors++;
    if (bad_rsp !== 0) begin
      miscompares++;
      $display("FAIL b2b_value: got %0d wrong responses want 0 (exp hi=%h lo=%h)", bad_rsp, ehi, elo);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo, ehi, elo;
    logic        div, dbz, edbz;
    int          lat, elat;
    bit          busy, tmo;
    for (int i = 0; i < 30; i++) begin
      div = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      ref_model(div, a, b, ehi, elo, edbz, elat);
      run_op(div, a, b, hi, lo, dbz, lat, busy, tmo);
      vectors++;
      if (tmo || {hi, lo, dbz} !== {ehi, elo, edbz}) begin
        miscompares++;
        $display("FAIL random_%0d: div=%b a=%h b=%h got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, div, a, b, hi, lo, dbz, ehi, elo, edbz);
      end
      vectors++;
      if (lat !== elat) begin
        miscompares++;
        $display("FAIL random_lat_%0d: got %0d cycles want %0d", i, lat, elat);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_rsp();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_dbz();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
